// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared funct3 constants and FSM state encoding for dmem_responder
package dmem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request/response handshake bundle
// master: core-side initiator (drives req_*, rsp_ready)
// slave : responder (drives req_ready, rsp_valid, rsp_rdata, rsp_err)
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - RV32I byte/half/word lane extraction, store merge and alignment check
// funct3/addr_lo select the lane; word is the stored word, wdata the right-aligned store data
// load_data: extended load result; store_word: word with the store lanes merged; misalign: bad alignment
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = 8'(word >> {addr_lo, 3'b000});
    assign lane_h = 16'(word >> {addr_lo[1], 4'b0000});

    always_comb begin
        load_data = '0;
        misalign  = 1'b0;
        case (funct3)
            F3_LB:  load_data = {{24{lane_b[7]}}, lane_b};
            F3_LBU: load_data = {24'd0, lane_b};
            F3_LH: begin
                load_data = {{16{lane_h[15]}}, lane_h};
                misalign  = addr_lo[0];
            end
            F3_LHU: begin
                load_data = {16'd0, lane_h};
                misalign  = addr_lo[0];
            end
            F3_LW: begin
                load_data = word;
                misalign  = |addr_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        store_word = word;
        case (funct3)
            F3_SB:   store_word[{addr_lo, 3'b000} +: 8]    = wdata[7:0];
            F3_SH:   store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            F3_SW:   store_word = wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency RV32I data-memory responder behind a valid/ready handshake
// clk/reset: rising-edge clock, synchronous active-high reset
// bus (slave): request accepted in IDLE, response presented LATENCY cycles later until rsp_ready
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic [2:0]        l_f3;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [IDX_W-1:0]  idx;
    logic              out_of_range;
    logic              illegal_f3;
    logic              misalign;
    logic              req_err;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign idx          = l_addr[IDX_W+1:2];
    assign out_of_range = |l_addr[31:IDX_W+2];
    // Loads allow 000,001,010,100,101; stores allow only 000,001,010.
    assign illegal_f3   = l_we ? (l_f3 >= 3'b011) : ((l_f3 == 3'b011) || (l_f3[2:1] == 2'b11));
    assign req_err      = misalign | out_of_range | illegal_f3;

    dmem_lane_align u_align (
        .funct3     (l_f3),
        .addr_lo    (l_addr[1:0]),
        .word       (mem[idx]),
        .wdata      (l_wdata),
        .load_data  (load_data),
        .store_word (store_word),
        .misalign   (misalign)
    );

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (cnt == '0) state_nxt = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            l_f3    <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        l_we    <= bus.req_we;
                        l_addr  <= bus.req_addr;
                        l_wdata <= bus.req_wdata;
                        l_f3    <= bus.req_funct3;
                        cnt     <= CNT_LOAD;
                    end
                end
                S_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // The store commits on the same edge the response is registered.
                        err_q   <= req_err;
                        rdata_q <= (!req_err && !l_we) ? load_data : 32'd0;
                        if (!req_err && l_we) mem[idx] <= store_word;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder with a byte-array reference model
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;
    logic reset1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mb [128];

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) mb[i] = 8'h00;
    endtask

    // Byte-addressed reference: legality, alignment, range, then byte-wise access.
    task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] rd, output logic er);
        int  size;
        logic ill;
        rd = 32'd0;
        er = 1'b0;
        if (we) ill = (f3 > 3'd2);
        else    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        if (ill || (a >= 32'd128) || ((a % size) != 0)) begin
            er = 1'b1;
        end else if (we) begin
            for (int i = 0; i < size; i++) mb[int'(a) + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) rd[8*i +: 8] = mb[int'(a) + i];
            if (!f3[2] && size < 4 && rd[8*size-1])
                for (int b = 8*size; b < 32; b++) rd[b] = 1'b1;
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int hold, input string tag);
        logic [31:0] erd;
        logic        er;
        int          n;
        model(we, a, wd, f3, erd, er);
        bus.req_we     = we;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_funct3 = f3;
        bus.req_valid  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_funct3 = 3'($urandom);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd2);
        for (int h = 0; h < hold; h++) begin
            chk({tag, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, " hold rdata"}, bus.rsp_rdata, erd);
            chk({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        chk({tag, " rdata"}, bus.rsp_rdata, erd);
        chk({tag, " err"}, 32'(bus.rsp_err), 32'(er));
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, " post valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " post req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        reset  = 1'b1;
        reset1 = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_funct3 = 3'd0;
        bus.rsp_ready  = 1'b0;
        bus1.req_valid  = 1'b0;
        bus1.req_we     = 1'b0;
        bus1.req_addr   = 32'd0;
        bus1.req_wdata  = 32'd0;
        bus1.req_funct3 = 3'd2;
        bus1.rsp_ready  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        reset  = 1'b0;
        reset1 = 1'b0;
        @(posedge clk); #1;

        xact(1'b1, 32'h08, 32'hDEADBEEF, 3'b010, 0, "sw08");
        xact(1'b0, 32'h08, 32'h0,        3'b010, 0, "lw08");

        xact(1'b1, 32'h0C, 32'h11223344, 3'b010, 0, "sw0c");
        xact(1'b1, 32'h0D, 32'h000000A5, 3'b000, 0, "sb0d");
        xact(1'b0, 32'h0C, 32'h0,        3'b010, 0, "lw0c");
        xact(1'b0, 32'h0D, 32'h0,        3'b000, 0, "lb0d");
        xact(1'b0, 32'h0D, 32'h0,        3'b100, 0, "lbu0d");

        xact(1'b0, 32'h03, 32'h0,        3'b001, 0, "lh03 err");
        xact(1'b1, 32'h06, 32'hCAFEF00D, 3'b010, 0, "sw06 err");
        xact(1'b0, 32'h04, 32'h0,        3'b010, 0, "lw04 unchanged");
        xact(1'b0, 32'h80, 32'h0,        3'b010, 0, "lw80 err");
        xact(1'b0, 32'h08, 32'h0,        3'b011, 0, "f3_011 err");
        xact(1'b1, 32'h08, 32'h55555555, 3'b011, 0, "st f3_011 err");
        xact(1'b0, 32'h08, 32'h0,        3'b010, 0, "lw08 unchanged");

        xact(1'b0, 32'h08, 32'h0,        3'b010, 5, "backpressure");

        // Reset during BUSY aborts the pending store and clears memory.
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h12345678;
        bus.req_funct3 = 3'b010;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        chk("abort req_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        xact(1'b0, 32'h10, 32'h0, 3'b010, 0, "lw10 after abort");
        xact(1'b0, 32'h08, 32'h0, 3'b010, 0, "lw08 cleared");

        // LATENCY=1 instance with rsp_ready tied high and a request always offered.
        bus1.rsp_ready = 1'b1;
        bus1.req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("lat1 req_ready idle", 32'(bus1.req_ready), 32'd1);
            @(posedge clk); #1;
            chk("lat1 busy valid", 32'(bus1.rsp_valid), 32'd0);
            chk("lat1 busy req_ready", 32'(bus1.req_ready), 32'd0);
            @(posedge clk); #1;
            chk("lat1 rsp_valid", 32'(bus1.rsp_valid), 32'd1);
            chk("lat1 rdata", bus1.rsp_rdata, 32'd0);
            chk("lat1 err", 32'(bus1.rsp_err), 32'd0);
            @(posedge clk); #1;
        end
        bus1.req_valid = 1'b0;

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else                           a = 32'($urandom_range(0, 131));
            xact(1'($urandom), a, $urandom, 3'($urandom), int'($urandom_range(0, 2)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
